// File: rtl/seg_pkg.sv
// Shared types and constants for the multiplexed 7-segment scan decoder.
// Segment patterns are active-high gfedcba (bit0 = a).
package seg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_TRACK,
        ST_HOLD
    } state_t;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h67;
    localparam logic [6:0] SEG_9T    = 7'h6F;
    localparam logic [6:0] SEG_A     = 7'h77;
    localparam logic [6:0] SEG_B     = 7'h7C;
    localparam logic [6:0] SEG_C     = 7'h39;
    localparam logic [6:0] SEG_D     = 7'h5E;
    localparam logic [6:0] SEG_E     = 7'h79;
    localparam logic [6:0] SEG_F     = 7'h71;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam int DEF_STABLE_CYCLES  = 16;
    localparam int DEF_TIMEOUT_CYCLES = 1048576;

    function automatic logic one_low(input logic [3:0] an);
        return (an == 4'b1110) || (an == 4'b1101) ||
               (an == 4'b1011) || (an == 4'b0111);
    endfunction

    function automatic logic [1:0] low_idx(input logic [3:0] an);
        logic [1:0] idx;
        idx = 2'd3;
        if (!an[0])
            idx = 2'd0;
        else if (!an[1])
            idx = 2'd1;
        else if (!an[2])
            idx = 2'd2;
        return idx;
    endfunction

endpackage

// File: rtl/seg_pattern_decode.sv
// Combinational 7-segment pattern to hex nibble decoder.
// Blank is legal but carries no digit; anything unlisted is illegal.
module seg_pattern_decode
    import seg_pkg::*;
(
    input  logic [6:0] i_pat,
    output logic [3:0] o_nib,
    output logic       o_legal,
    output logic       o_blank
);

    always_comb begin
        o_nib   = 4'h0;
        o_legal = 1'b1;
        o_blank = 1'b0;
        case (i_pat)
            SEG_0:         o_nib = 4'h0;
            SEG_1:         o_nib = 4'h1;
            SEG_2:         o_nib = 4'h2;
            SEG_3:         o_nib = 4'h3;
            SEG_4:         o_nib = 4'h4;
            SEG_5:         o_nib = 4'h5;
            SEG_6:         o_nib = 4'h6;
            SEG_7:         o_nib = 4'h7;
            SEG_8:         o_nib = 4'h8;
            SEG_9, SEG_9T: o_nib = 4'h9;
            SEG_A:         o_nib = 4'hA;
            SEG_B:         o_nib = 4'hB;
            SEG_C:         o_nib = 4'hC;
            SEG_D:         o_nib = 4'hD;
            SEG_E:         o_nib = 4'hE;
            SEG_F:         o_nib = 4'hF;
            SEG_BLANK:     o_blank = 1'b1;
            default:       o_legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg_scan_decoder.sv
// Snoops a multiplexed 7-segment display bus and recovers the shown digits.
// A digit is captured once its anode/segment pair has been stable long enough.
module seg_scan_decoder
    import seg_pkg::*;
#(
    parameter int STABLE_CYCLES  = DEF_STABLE_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  segin,
    input  logic [3:0]  anin,
    output logic [15:0] hexout,
    output logic [3:0]  dpout,
    output logic [3:0]  digvalid,
    output logic [3:0]  segerr,
    output logic        capture
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TMO_ONE  = TW'(1);
    localparam logic [7:0]    STB_LAST = 8'(STABLE_CYCLES - 1);

    state_t        r_state;
    logic [7:0]    r_cnt;
    logic [3:0]    r_an;
    logic [7:0]    r_seg;
    logic [15:0]   r_hex;
    logic [3:0]    r_dp;
    logic [3:0]    r_valid;
    logic [3:0]    r_err;
    logic          r_cap;
    logic [TW-1:0] r_tmo [4];

    logic       w_same;
    logic       w_one;
    logic       w_fire;
    logic [1:0] w_idx;
    logic [6:0] w_pat;
    logic [3:0] w_nib;
    logic       w_legal;
    logic       w_blank;

    assign w_same = (anin == r_an) && (segin == r_seg);
    assign w_one  = one_low(anin);
    assign w_fire = (r_state == ST_TRACK) && w_same && (r_cnt == STB_LAST);
    assign w_idx  = low_idx(r_an);
    assign w_pat  = ~r_seg[6:0];

    seg_pattern_decode u_dec (
        .i_pat   (w_pat),
        .o_nib   (w_nib),
        .o_legal (w_legal),
        .o_blank (w_blank)
    );

    // HOLD reacts to a change exactly as IDLE would on the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= 8'd0;
            r_an    <= 4'hF;
            r_seg   <= 8'hFF;
        end else if (r_state == ST_IDLE || !w_same) begin
            if (w_one) begin
                r_state <= ST_TRACK;
                r_cnt   <= 8'd1;
                r_an    <= anin;
                r_seg   <= segin;
            end else begin
                r_state <= ST_IDLE;
                r_cnt   <= 8'd0;
            end
        end else if (r_state == ST_TRACK) begin
            if (r_cnt == STB_LAST)
                r_state <= ST_HOLD;
            else
                r_cnt <= r_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hex   <= 16'h0000;
            r_dp    <= 4'h0;
            r_valid <= 4'h0;
            r_err   <= 4'h0;
            r_cap   <= 1'b0;
            for (int n = 0; n < 4; n++)
                r_tmo[n] <= '0;
        end else begin
            r_cap <= w_fire;
            for (int n = 0; n < 4; n++) begin
                if (w_fire && w_idx == 2'(n) && w_legal)
                    r_tmo[n] <= TMO_LOAD;
                else if (r_tmo[n] != '0)
                    r_tmo[n] <= r_tmo[n] - TMO_ONE;

                // A capture on the expiring cycle overrides the timeout.
                if (w_fire && w_idx == 2'(n)) begin
                    r_err[n]   <= ~w_legal;
                    r_valid[n] <= w_legal & ~w_blank;
                    if (w_legal)
                        r_dp[n] <= ~r_seg[7];
                    if (w_legal && !w_blank)
                        r_hex[4*n +: 4] <= w_nib;
                end else if (r_tmo[n] == TMO_ONE) begin
                    r_valid[n] <= 1'b0;
                end
            end
        end
    end

    assign hexout   = r_hex;
    assign dpout    = r_dp;
    assign digvalid = r_valid;
    assign segerr   = r_err;
    assign capture  = r_cap;

endmodule
